// File: rtl/kuznechik_pkg.sv
// rtl/kuznechik_pkg.sv - shared types for the kuznechik cipher arbiter
package kuznechik_pkg;

    localparam int KUZ_BLOCK_W = 128;

    typedef logic [KUZ_BLOCK_W-1:0] kuz_block_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK,
        RESP
    } arb_state_e;

endpackage

// File: rtl/kuznechik_cipher_arbiter_if.sv
// rtl/kuznechik_cipher_arbiter_if.sv - requester and cipher-core handshake bundle
interface kuznechik_cipher_arbiter_if #(
    parameter int N_REQ = 2
);
    import kuznechik_pkg::*;

    logic [N_REQ-1:0]             req_valid_i;
    logic [N_REQ-1:0]             req_ready_o;
    kuz_block_t [N_REQ-1:0]       req_data_i;
    logic [N_REQ-1:0]             rsp_valid_o;
    logic [N_REQ-1:0]             rsp_ready_i;
    kuz_block_t                   rsp_data_o;
    logic                         rsp_err_o;
    logic                         cipher_rst_o;
    logic                         cipher_req_o;
    logic                         cipher_ack_o;
    kuz_block_t                   cipher_data_o;
    logic                         cipher_busy_i;
    logic                         cipher_valid_i;
    kuz_block_t                   cipher_data_i;

    modport slave (
        input  req_valid_i, req_data_i, rsp_ready_i,
        input  cipher_busy_i, cipher_valid_i, cipher_data_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
        output cipher_rst_o, cipher_req_o, cipher_ack_o, cipher_data_o
    );

    modport master (
        output req_valid_i, req_data_i, rsp_ready_i,
        output cipher_busy_i, cipher_valid_i, cipher_data_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
        input  cipher_rst_o, cipher_req_o, cipher_ack_o, cipher_data_o
    );

endinterface

// File: rtl/kuznechik_rr_arbiter.sv
// rtl/kuznechik_rr_arbiter.sv - combinational round-robin pick starting at ptr
module kuznechik_rr_arbiter #(
    parameter  int N_REQ = 2,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = IDX_W'((int'(ptr) + i) % N_REQ);
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/kuznechik_cipher_arbiter.sv
// rtl/kuznechik_cipher_arbiter.sv - round-robin sharing of one kuznechik core with watchdog
module kuznechik_cipher_arbiter
    import kuznechik_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    kuznechik_cipher_arbiter_if.slave bus,
    output logic                      busy_o
);

    localparam int               IDX_W    = $clog2(N_REQ);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    arb_state_e       state, state_nxt;
    kuz_block_t       operand, result;
    logic             err;
    logic [IDX_W-1:0] owner, ptr, gnt_idx;
    logic [N_REQ-1:0] gnt, owner_oh;
    logic [CNT_W-1:0] cnt;
    logic             timeout, owner_ready;

    kuznechik_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req (bus.req_valid_i),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign timeout     = (cnt == CNT_LAST);
    assign owner_ready = bus.rsp_ready_i[owner];

    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // A core still busy or holding a stale valid (e.g. recovering from a soft reset) stalls ISSUE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|bus.req_valid_i) state_nxt = ISSUE;
            ISSUE:   if (!bus.cipher_busy_i && !bus.cipher_valid_i) state_nxt = WAIT;
            WAIT: begin
                if (bus.cipher_valid_i) state_nxt = ACK;
                else if (timeout)       state_nxt = RESP;
            end
            ACK:     state_nxt = RESP;
            RESP:    if (owner_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o           = (state != IDLE);
        bus.req_ready_o  = (state == IDLE) ? gnt : '0;
        bus.cipher_req_o = (state == ISSUE) && !bus.cipher_busy_i && !bus.cipher_valid_i;
        bus.cipher_ack_o = (state == ACK);
        bus.cipher_rst_o = (state == WAIT) && !bus.cipher_valid_i && timeout;
        bus.rsp_valid_o  = (state == RESP) ? owner_oh : '0;
    end

    assign bus.rsp_data_o    = result;
    assign bus.rsp_err_o     = err;
    assign bus.cipher_data_o = operand;

    // Valid beats the watchdog when both land in the same WAIT cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            operand <= '0;
            result  <= '0;
            err     <= 1'b0;
            owner   <= '0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req_valid_i) begin
                        operand <= bus.req_data_i[gnt_idx];
                        owner   <= gnt_idx;
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    if (bus.cipher_valid_i) begin
                        result <= bus.cipher_data_i;
                        err    <= 1'b0;
                    end else if (timeout) begin
                        result <= '0;
                        err    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (owner_ready) ptr <= (owner == IDX_LAST) ? '0 : owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kuznechik_cipher_arbiter.sv
// tb/tb_kuznechik_cipher_arbiter.sv - scoreboard bench with a stub cipher core
module tb_kuznechik_cipher_arbiter;
    import kuznechik_pkg::*;

    localparam int         N   = 2;
    localparam int         TMO = 8;
    localparam kuz_block_t PT  = 128'h1122334455667700ffeeddccbbaa9988;
    localparam kuz_block_t CT  = 128'h7f679d90bebc24305a468d42b9d4edcd;

    typedef struct packed {
        logic [1:0] port;
        kuz_block_t data;
        logic       err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_i;
    logic busy_o;

    always #5 clk = ~clk;

    kuznechik_cipher_arbiter_if #(.N_REQ(N)) bus ();

    kuznechik_cipher_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .bus    (bus.slave),
        .busy_o (busy_o)
    );

    int         n_vec = 0, n_err = 0, n_rsp = 0;
    kuz_block_t src_q [N][$];
    logic [N-1:0] rsp_mask = '1;
    int         core_lat = 2;
    bit         core_hang = 1'b0;
    rsp_t       exp_q[$];
    int         grant_q[$];
    int         cyc = 0, n_creq = 0, n_cack = 0, n_crst = 0;
    int         creq_cyc = 0, cack_cyc = 0, crst_cyc = 0, cval_cyc = 0, rspv_cyc = 0, acc_cyc = 0;

    // Stub core: the GOST vector maps to its reference ciphertext, anything else to a fixed mix
    function automatic kuz_block_t core_fn(input kuz_block_t d);
        if (d == PT) return CT;
        return {d[63:0], d[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic kuz_block_t rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Environment: samples on negedge, drives requesters and the core one step after posedge
    initial begin : env
        logic [N-1:0] acc, hs;
        bit           creq_s, cack_s, crst_s, rst_s, cval_prev, rspv_prev, c_busy, c_valid;
        kuz_block_t   cap, c_op, tmp;
        int           c_rem, p;
        rsp_t         got, e;
        bus.req_valid_i    = '0;
        bus.req_data_i     = '0;
        bus.rsp_ready_i    = '0;
        bus.cipher_busy_i  = 1'b0;
        bus.cipher_valid_i = 1'b0;
        bus.cipher_data_i  = '0;
        c_busy = 0; c_valid = 0; c_rem = 0; c_op = '0; cap = '0; cval_prev = 0; rspv_prev = 0;
        forever begin
            @(negedge clk);
            rst_s = rst_i; acc = '0; hs = '0; creq_s = 0; cack_s = 0; crst_s = 0;
            if (!rst_s) begin
                acc    = bus.req_ready_o & bus.req_valid_i;
                hs     = bus.rsp_valid_o & bus.rsp_ready_i;
                creq_s = bus.cipher_req_o;
                cack_s = bus.cipher_ack_o;
                crst_s = bus.cipher_rst_o;
                if (acc != '0) begin
                    p = oh_idx(acc);
                    grant_q.push_back(p);
                    acc_cyc = cyc;
                    e.port = 2'(p);
                    e.data = core_hang ? '0 : core_fn(bus.req_data_i[p]);
                    e.err  = core_hang;
                    exp_q.push_back(e);
                end
                if (hs != '0) begin
                    got.port = 2'(oh_idx(hs));
                    got.data = bus.rsp_data_o;
                    got.err  = bus.rsp_err_o;
                    n_rsp++;
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL sb_unexpected: got port %0d err %b data %h, required no response",
                                 got.port, got.err, got.data);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            n_err++;
                            $display("FAIL sb_rsp: got port %0d err %b data %h, required port %0d err %b data %h",
                                     got.port, got.err, got.data, e.port, e.err, e.data);
                        end
                    end
                end
                if (creq_s) begin n_creq++; creq_cyc = cyc; cap = bus.cipher_data_o; end
                if (cack_s) begin n_cack++; cack_cyc = cyc; end
                if (crst_s) begin n_crst++; crst_cyc = cyc; end
                if (bus.cipher_valid_i && !cval_prev) cval_cyc = cyc;
                if (|bus.rsp_valid_o && !rspv_prev) rspv_cyc = cyc;
                cval_prev = bus.cipher_valid_i;
                rspv_prev = |bus.rsp_valid_o;
            end
            @(posedge clk);
            #1;
            cyc++;
            for (int q = 0; q < N; q++) begin
                if (acc[q] && src_q[q].size() > 0) tmp = src_q[q].pop_front();
                bus.req_valid_i[q] = (src_q[q].size() > 0);
                bus.req_data_i[q]  = (src_q[q].size() > 0) ? src_q[q][0] : '0;
            end
            bus.rsp_ready_i = rsp_mask;
            if (rst_s || crst_s) begin
                c_busy = 0; c_valid = 0; c_rem = 0;
            end else if (cack_s) begin
                c_valid = 0;
            end else if (creq_s) begin
                c_busy = 1; c_rem = core_lat; c_op = cap;
            end else if (c_busy && !core_hang) begin
                c_rem--;
                if (c_rem <= 0) begin c_busy = 0; c_valid = 1; end
            end
            bus.cipher_busy_i  = c_busy;
            bus.cipher_valid_i = c_valid;
            bus.cipher_data_i  = c_valid ? core_fn(c_op) : '0;
        end
    end

    task automatic wait_rsp(input int target, input string name);
        int i = 0;
        while (n_rsp < target && i < 400) begin @(posedge clk); i++; end
        n_vec++;
        if (n_rsp < target) begin
            n_err++;
            $display("FAIL %s_timeout: responses %0d, required %0d", name, n_rsp, target);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({busy_o, bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.cipher_rst_o,
             bus.cipher_req_o, bus.cipher_ack_o} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: got busy %b rdy %b rspv %b err %b crst %b creq %b cack %b, required all 0",
                     busy_o, bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.cipher_rst_o,
                     bus.cipher_req_o, bus.cipher_ack_o);
        end
        n_vec++;
        if (bus.rsp_data_o !== '0) begin
            n_err++; $display("FAIL reset_rsp_data: got %h, required 0", bus.rsp_data_o);
        end
        n_vec++;
        if (bus.cipher_data_o !== '0) begin
            n_err++; $display("FAIL reset_cipher_data: got %h, required 0", bus.cipher_data_o);
        end
    endtask

    task automatic test_contention();
        int base = n_rsp;
        grant_q.delete();
        core_lat = 2;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            src_q[0].push_back(rnd());
            src_q[1].push_back(rnd());
        end
        wait_rsp(base + 8, "contention");
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if (k >= grant_q.size() || grant_q[k] != k % 2) begin
                n_err++;
                $display("FAIL contention_grant%0d: got %0d, required %0d", k,
                         (k < grant_q.size()) ? grant_q[k] : -1, k % 2);
            end
        end
    endtask

    task automatic test_single();
        int base = n_rsp, r0 = n_creq, a0 = n_cack;
        core_lat = 3;
        @(posedge clk);
        src_q[0].push_back(PT);
        wait_rsp(base + 1, "single");
        n_vec++;
        if (n_creq - r0 != 1 || n_cack - a0 != 1) begin
            n_err++;
            $display("FAIL single_pulses: got req %0d ack %0d, required 1 and 1", n_creq - r0, n_cack - a0);
        end
        n_vec++;
        if (creq_cyc != acc_cyc + 1) begin
            n_err++; $display("FAIL single_req_lat: got %0d, required 1", creq_cyc - acc_cyc);
        end
        n_vec++;
        if (cack_cyc != cval_cyc + 1 || rspv_cyc != cval_cyc + 2) begin
            n_err++;
            $display("FAIL single_rsp_lat: got ack +%0d rspv +%0d, required +1 and +2",
                     cack_cyc - cval_cyc, rspv_cyc - cval_cyc);
        end
    endtask

    task automatic test_backpressure();
        int           base = n_rsp, i = 0, a0;
        logic [N-1:0] v0;
        kuz_block_t   d0;
        rsp_mask = '0;
        @(posedge clk);
        src_q[0].push_back(rnd());
        src_q[0].push_back(rnd());
        src_q[1].push_back(rnd());
        while (bus.rsp_valid_o === '0 && i < 100) begin @(negedge clk); i++; end
        v0 = bus.rsp_valid_o; d0 = bus.rsp_data_o; a0 = n_cack;
        rsp_mask = ~v0;
        n_vec++;
        if (v0 === '0) begin n_err++; $display("FAIL bp_valid: got none, required a response"); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_vec++;
            if (bus.rsp_valid_o !== v0 || bus.rsp_data_o !== d0 || bus.req_ready_o !== '0 || n_cack != a0) begin
                n_err++;
                $display("FAIL bp_hold%0d: got v %b d %h rdy %b acks %0d, required v %b d %h rdy 0 acks %0d",
                         k, bus.rsp_valid_o, bus.rsp_data_o, bus.req_ready_o, n_cack, v0, d0, a0);
            end
        end
        rsp_mask = '1;
        wait_rsp(base + 3, "bp_drain");
    endtask

    task automatic test_hung();
        int base = n_rsp, s0 = n_crst;
        core_hang = 1'b1;
        @(posedge clk);
        src_q[1].push_back(rnd());
        wait_rsp(base + 1, "hung");
        n_vec++;
        if (n_crst - s0 != 1 || crst_cyc - creq_cyc != TMO) begin
            n_err++;
            $display("FAIL hung_rst: got %0d pulses at +%0d, required 1 at +%0d", n_crst - s0, crst_cyc - creq_cyc, TMO);
        end
        n_vec++;
        if (rspv_cyc != crst_cyc + 1) begin
            n_err++; $display("FAIL hung_rsp_lat: got +%0d, required +1", rspv_cyc - crst_cyc);
        end
        core_hang = 1'b0;
        core_lat  = 2;
        src_q[0].push_back(rnd());
        wait_rsp(base + 2, "hung_recover");
        n_vec++;
        if (n_crst - s0 != 1) begin
            n_err++; $display("FAIL hung_recover_rst: got %0d pulses, required 1", n_crst - s0);
        end
    endtask

    task automatic test_valid_at_timeout();
        int base = n_rsp, s0 = n_crst;
        core_lat = TMO - 1;
        @(posedge clk);
        src_q[0].push_back(rnd());
        wait_rsp(base + 1, "vat");
        n_vec++;
        if (n_crst != s0 || cval_cyc - creq_cyc != TMO) begin
            n_err++;
            $display("FAIL vat_race: got %0d rst pulses, valid at +%0d, required 0 pulses at +%0d",
                     n_crst - s0, cval_cyc - creq_cyc, TMO);
        end
        core_lat = 2;
    endtask

    task automatic test_reset_mid_wait();
        int base, r0, i = 0;
        core_lat = 5;
        @(posedge clk);
        src_q[0].push_back(rnd());
        wait_rsp(n_rsp + 1, "mid_pre");
        base = n_rsp; r0 = n_creq;
        src_q[0].push_back(rnd());
        while (n_creq == r0 && i < 100) begin @(posedge clk); i++; end
        #1 rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({busy_o, bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.cipher_rst_o,
             bus.cipher_req_o, bus.cipher_ack_o} !== '0 || bus.rsp_data_o !== '0 || bus.cipher_data_o !== '0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got busy %b rspv %b creq %b cdata %h, required all 0",
                     busy_o, bus.rsp_valid_o, bus.cipher_req_o, bus.cipher_data_o);
        end
        if (exp_q.size() > 0) exp_q.pop_back();
        repeat (20) @(posedge clk);
        n_vec++;
        if (n_rsp != base) begin
            n_err++; $display("FAIL mid_dropped: got %0d responses, required 0", n_rsp - base);
        end
        grant_q.delete();
        core_lat = 2;
        src_q[0].push_back(rnd());
        src_q[1].push_back(rnd());
        wait_rsp(base + 2, "mid_post");
        n_vec++;
        if (grant_q.size() == 0 || grant_q[0] != 0) begin
            n_err++;
            $display("FAIL mid_ptr: got first grant %0d, required 0", (grant_q.size() > 0) ? grant_q[0] : -1);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit, required completion");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_backpressure();
        test_hung();
        test_valid_at_timeout();
        test_reset_mid_wait();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
